// File: rtl/shift_expand.sv
// shift_expand: widening power-of-two gain stage on a valid/ready stream.
//
// Narrow signed samples are scaled by 2^k (arithmetic left shift) into a wide
// signed word. Results outside the wide range clip to MAX/MIN. The shift k is
// captured on the first sample of each frame and held for the whole frame.
// A saturating event counter and a sticky flag report clipped samples that
// leave on the output stream.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   shift           left-shift amount (unsigned), taken at frame start only
//   clear           synchronous clear of sat_count / sat_flag
//   s_valid/s_ready input handshake; s_data signed sample, s_last end of frame
//   m_valid/m_ready output handshake; m_data signed result, m_last end of frame
//   sat_count       saturated samples transferred on output (holds at max)
//   sat_flag        sticky: a saturated sample has been transferred
module shift_expand #(
  parameter int S_WIDTH     = 16,
  parameter int M_WIDTH     = 32,
  parameter int SHIFT_WIDTH = 5,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          clear,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [S_WIDTH-1:0]     s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [M_WIDTH-1:0]     m_data,
  output logic                          m_last,
  output logic        [COUNT_WIDTH-1:0] sat_count,
  output logic                          sat_flag
);

  if (M_WIDTH < S_WIDTH) begin : g_width_check
    $error("shift_expand: M_WIDTH must be >= S_WIDTH");
  end

  localparam logic signed [M_WIDTH-1:0] MAX_VAL = {1'b0, {(M_WIDTH-1){1'b1}}};
  localparam logic signed [M_WIDTH-1:0] MIN_VAL = {1'b1, {(M_WIDTH-1){1'b0}}};

  // Returns {sat, result}. x is already sign-extended to the wide width, so
  // the shift fits exactly iff shifting back arithmetically restores x.
  function automatic logic [M_WIDTH:0] shift_sat(
    input logic signed [M_WIDTH-1:0]     x,
    input logic        [SHIFT_WIDTH-1:0] k
  );
    logic signed [M_WIDTH-1:0] y;
    logic signed [M_WIDTH-1:0] back;
    logic                      sat;
    y    = x <<< k;
    back = y >>> k;
    if (x == '0) begin
      sat = 1'b0;
    end else if (int'(k) >= M_WIDTH) begin
      sat = 1'b1;
    end else begin
      sat = (back != x);
    end
    if (sat) begin
      y = x[M_WIDTH-1] ? MIN_VAL : MAX_VAL;
    end
    return {sat, y};
  endfunction

  // Control state (reset)
  logic                          vld_p1_q, vld_p1_d;
  logic                          vld_p2_q, vld_p2_d;
  logic                          frame_start_q, frame_start_d;
  logic        [COUNT_WIDTH-1:0] sat_count_q, sat_count_d;
  logic                          sat_flag_q, sat_flag_d;

  // Datapath state (no reset)
  logic        [SHIFT_WIDTH-1:0] shift_hold_q, shift_hold_d;
  logic signed [M_WIDTH-1:0]     data_p1_q, data_p1_d;
  logic                          last_p1_q, last_p1_d;
  logic        [SHIFT_WIDTH-1:0] k_p1_q, k_p1_d;
  logic signed [M_WIDTH-1:0]     data_p2_q, data_p2_d;
  logic                          last_p2_q, last_p2_d;
  logic                          sat_p2_q, sat_p2_d;

  logic                          e1, e2;
  logic                          s_hs, m_hs;
  logic        [SHIFT_WIDTH-1:0] shift_act;
  logic        [M_WIDTH:0]       shift_res;

  always_comb begin
    e2        = !vld_p2_q || m_ready;
    e1        = !vld_p1_q || e2;
    s_hs      = s_valid && e1;
    m_hs      = vld_p2_q && m_ready;
    shift_act = frame_start_q ? shift : shift_hold_q;
    shift_res = shift_sat(data_p1_q, k_p1_q);

    vld_p1_d      = vld_p1_q;
    vld_p2_d      = vld_p2_q;
    frame_start_d = frame_start_q;
    shift_hold_d  = shift_hold_q;
    data_p1_d     = data_p1_q;
    last_p1_d     = last_p1_q;
    k_p1_d        = k_p1_q;
    data_p2_d     = data_p2_q;
    last_p2_d     = last_p2_q;
    sat_p2_d      = sat_p2_q;
    sat_count_d   = sat_count_q;
    sat_flag_d    = sat_flag_q;

    // Frame tracking: the shift seen at frame start is reused until s_last.
    if (s_hs) begin
      shift_hold_d  = shift_act;
      frame_start_d = s_last;
    end

    // Stage p1: sign-extend and capture the active shift
    if (e1) begin
      vld_p1_d  = s_valid;
      data_p1_d = M_WIDTH'(s_data);
      last_p1_d = s_last;
      k_p1_d    = shift_act;
    end

    // Stage p2: shift, detect overflow, clip
    if (e2) begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = signed'(shift_res[M_WIDTH-1:0]);
      sat_p2_d  = shift_res[M_WIDTH];
      last_p2_d = last_p1_q;
    end

    // Clear takes priority over a coincident increment.
    if (clear) begin
      sat_count_d = '0;
      sat_flag_d  = 1'b0;
    end else if (m_hs && sat_p2_q) begin
      sat_flag_d = 1'b1;
      if (sat_count_q != '1) begin
        sat_count_d = sat_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      frame_start_q <= 1'b1;
      sat_count_q   <= '0;
      sat_flag_q    <= 1'b0;
    end else begin
      vld_p1_q      <= vld_p1_d;
      vld_p2_q      <= vld_p2_d;
      frame_start_q <= frame_start_d;
      sat_count_q   <= sat_count_d;
      sat_flag_q    <= sat_flag_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_hold_q <= shift_hold_d;
    data_p1_q    <= data_p1_d;
    last_p1_q    <= last_p1_d;
    k_p1_q       <= k_p1_d;
    data_p2_q    <= data_p2_d;
    last_p2_q    <= last_p2_d;
    sat_p2_q     <= sat_p2_d;
  end

  assign s_ready   = e1;
  assign m_valid   = vld_p2_q;
  assign m_data    = data_p2_q;
  assign m_last    = last_p2_q;
  assign sat_count = sat_count_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_shift_expand.sv
// Bench for shift_expand: a value-level model (x * 2^k clipped to the wide
// range, frame-latched shift, saturating counter) checked every cycle, plus
// directed frames with hand-computed literal results.
module tb_shift_expand;
  localparam int S  = 16;
  localparam int M  = 32;
  localparam int SH = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [SH-1:0] shift;
  logic          clear;
  logic          s_valid;
  logic          s_ready;
  logic [S-1:0]  s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [M-1:0]  m_data;
  logic          m_last;
  logic [CW-1:0] sat_count;
  logic          sat_flag;

  shift_expand #(.S_WIDTH(S), .M_WIDTH(M), .SHIFT_WIDTH(SH), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .shift(shift), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sat_count(sat_count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // x * 2^k with clipping, computed in 64-bit integer arithmetic
  function automatic void model_out(input logic [S-1:0] d, input int k,
                                    output logic [M-1:0] o, output bit sat);
    longint x, v, maxv, minv;
    x    = longint'(signed'(d));
    maxv = (longint'(1) <<< (M - 1)) - 1;
    minv = -(longint'(1) <<< (M - 1));
    if (x == 0)       v = 0;
    else if (k >= 48) v = (x > 0) ? maxv + 1 : minv - 1;
    else              v = x * (longint'(1) <<< k);
    sat = (v > maxv) || (v < minv);
    if (sat) o = (x > 0) ? M'(maxv) : M'(minv);
    else     o = M'(v);
  endfunction

  typedef struct {
    logic [M-1:0] d;
    logic         l;
    bit           sat;
  } exp_t;

  exp_t         q[$];
  logic [M-1:0] cap_d[$];
  logic         cap_l[$];

  // Model and per-cycle compare; sampled mid-cycle while inputs are stable
  initial begin
    int   mcnt;
    bit   mflag;
    bit   mfs;
    int   mk;
    bit   armed;
    bit   hs;
    bit   hs_sat;
    exp_t e;
    mcnt = 0; mflag = 0; mfs = 1; mk = 0; armed = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        mcnt = 0; mflag = 0; mfs = 1; armed = 1;
      end else if (armed) begin
        check("mon_sat_count", sat_count, mcnt);
        check("mon_sat_flag", sat_flag, mflag);
        if (m_valid) begin
          if (q.size() == 0) check("mon_unexpected_valid", m_valid, 0);
          else begin
            check("mon_m_data", m_data, q[0].d);
            check("mon_m_last", m_last, q[0].l);
          end
        end
        hs = 0; hs_sat = 0;
        if (m_valid && m_ready && q.size() > 0) begin
          e = q.pop_front();
          hs = 1; hs_sat = e.sat;
          cap_d.push_back(m_data);
          cap_l.push_back(m_last);
        end
        if (clear) begin
          mcnt = 0; mflag = 0;
        end else if (hs && hs_sat) begin
          mflag = 1;
          if (mcnt < (1 << CW) - 1) mcnt++;
        end
        if (s_valid && s_ready) begin
          mk  = mfs ? int'(shift) : mk;
          mfs = s_last;
          model_out(s_data, mk, e.d, e.sat);
          e.l = s_last;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [S-1:0] d, input logic l, input logic [SH-1:0] sh);
    bit acc;
    int n;
    acc = 0; n = 0;
    s_valid = 1; s_data = d; s_last = l; shift = sh;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic expect_next(input string name, input logic [M-1:0] d, input int lat);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, lat);
    check(name, m_data, d);
  endtask

  task automatic drain();
    s_valid = 0;
    repeat (6) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int idx;
    int n;
    bit acc;
    logic [M-1:0] t4_exp [8];
    reset = 1; clear = 0; s_valid = 0; s_data = '0; s_last = 0; shift = '0; m_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("rst_m_valid", m_valid, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_sat_flag", sat_flag, 0);

    // Sign extension with zero shift
    send(16'hFFFF, 1, 0); s_valid = 0;
    check("t1_not_yet_valid", m_valid, 0);
    expect_next("t1_neg1", 32'hFFFF_FFFF, 1);
    drain();
    send(16'h7FFF, 1, 0); s_valid = 0;
    expect_next("t1_max16", 32'h0000_7FFF, 1);
    drain();
    check("t1_cnt", sat_count, 0);

    // Positive overflow, then exact MIN
    send(16'h4000, 1, 17); s_valid = 0;
    expect_next("t2_pos_sat", 32'h7FFF_FFFF, 1);
    drain();
    check("t2_cnt", sat_count, 1);
    check("t2_flag", sat_flag, 1);
    send(16'hC000, 1, 17); s_valid = 0;
    expect_next("t2_exact_min", 32'h8000_0000, 1);
    drain();
    check("t2_cnt_hold", sat_count, 1);

    // Negative edge cases and zero with the largest shift
    send(16'h8000, 1, 16); s_valid = 0;
    expect_next("t3_min_exact", 32'h8000_0000, 1);
    drain();
    check("t3_cnt_a", sat_count, 1);
    send(16'h8000, 1, 17); s_valid = 0;
    expect_next("t3_neg_sat", 32'h8000_0000, 1);
    drain();
    check("t3_cnt_b", sat_count, 2);
    send(16'h0000, 1, 31); s_valid = 0;
    expect_next("t3_zero", 32'h0000_0000, 1);
    drain();
    check("t3_cnt_c", sat_count, 2);

    // Frame latch: mid-frame shift changes are ignored
    base = cap_d.size();
    send(16'd1, 0, 0); send(16'd2, 0, 4); send(16'd3, 0, 4); send(16'd4, 1, 4);
    send(16'd1, 0, 4); send(16'd2, 0, 7); send(16'd3, 0, 7); send(16'd4, 1, 7);
    drain();
    t4_exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd16, 32'd32, 32'd48, 32'd64};
    check("t4_count", cap_d.size() - base, 8);
    if (cap_d.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t4_data%0d", i), cap_d[base+i], t4_exp[i]);
        check($sformatf("t4_last%0d", i), cap_l[base+i], (i == 3 || i == 7));
      end
    end

    // Backpressure: two samples fill the pipe, then ordered release
    base = cap_d.size();
    m_ready = 0; s_valid = 1; s_data = 16'h11; s_last = 0; shift = 0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; s_data = 16'h11 + 16'(idx); s_last = (idx == 3); end
    end
    check("t5_accepted", idx, 2);
    check("t5_s_ready_low", s_ready, 0);
    check("t5_m_valid", m_valid, 1);
    check("t5_m_data_hold", m_data, 32'h11);
    m_ready = 1; n = 0;
    while (idx < 4 && n < 20) begin
      @(negedge clk); acc = s_valid && s_ready;
      @(posedge clk); #1;
      n++;
      if (acc) begin idx++; s_data = 16'h11 + 16'(idx); s_last = (idx == 3); end
    end
    drain();
    check("t5_count", cap_d.size() - base, 4);
    if (cap_d.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t5_data%0d", i), cap_d[base+i], 32'h11 + 32'(i));
        check($sformatf("t5_last%0d", i), cap_l[base+i], (i == 3));
      end
    end

    // Counter saturation at all-ones
    m_ready = 1; s_valid = 1; s_data = 16'd1; s_last = 1; shift = 31;
    repeat (20) begin
      @(posedge clk); #1;
    end
    drain();
    check("t6_cnt_max", sat_count, 15);
    check("t6_flag", sat_flag, 1);

    // clear coincident with a saturated output transfer
    m_ready = 0;
    send(16'd1, 1, 31); s_valid = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("t6_stalled_valid", m_valid, 1);
    clear = 1; m_ready = 1;
    @(posedge clk); #1;
    clear = 0;
    check("t6_clear_cnt", sat_count, 0);
    check("t6_clear_flag", sat_flag, 0);
    check("t6_drained", m_valid, 0);

    // Reset with both stages full; next sample starts a new frame
    m_ready = 0;
    send(16'd3, 0, 5); send(16'd5, 0, 5); s_valid = 0;
    check("t7_full", s_ready, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("t7_rst_m_valid", m_valid, 0);
    check("t7_rst_s_ready", s_ready, 1);
    m_ready = 1;
    send(16'd3, 1, 2); s_valid = 0;
    expect_next("t7_reload_shift", 32'd12, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_expand.md
Name: shift_expand

Overview:
Widening counterpart to the stream saturator: accepts narrow signed samples, applies a runtime power-of-two gain (arithmetic left shift), and emits wide signed samples on a valid/ready stream. Overflow of the wide range clips to the output MIN or MAX. A per-frame shift is latched on the first sample of each frame. A saturating event counter is exposed for gain-control software.

Parameters:
S_WIDTH, 16, input sample width (signed two's complement)
M_WIDTH, 32, output sample width; must be >= S_WIDTH (elaboration error otherwise)
SHIFT_WIDTH, 5, width of shift control; shift range 0..2^SHIFT_WIDTH-1
COUNT_WIDTH, 16, width of saturation event counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
shift  in  SHIFT_WIDTH  left-shift amount, unsigned; sampled at frame start only
clear  in  1  synchronous clear of sat_count and sat_flag
s_valid  in  1  input sample valid
s_ready  out  1  input ready
s_data  in  S_WIDTH  input sample, signed
s_last  in  1  last sample of frame
m_valid  out  1  output valid
m_ready  in  1  output ready
m_data  out  M_WIDTH  output sample, signed
m_last  out  1  s_last delayed with its sample
sat_count  out  COUNT_WIDTH  number of saturated samples transferred on output
sat_flag  out  1  sticky: at least one saturated sample since last clear/reset

Behaviour:
- Reset values: m_valid=0, sat_count=0, sat_flag=0, internal stage valids=0, frame-start flag=1. m_data/m_last are don't-care until m_valid.
- Two-stage pipeline, latency exactly 2 cycles from input handshake to m_valid when unstalled; throughput 1 sample/cycle.
- Stage 1 (v1) registers the sign-extended s_data, s_last and the active shift. Stage 2 (v2, which drives m_valid) registers the shifted/saturated result.
- Stage 2 enable e2 = !v2 || m_ready. Stage 1 enable e1 = !v1 || e2. s_ready = e1, combinational from m_ready by design.
- Register contents change only when a stage is enabled. m_data/m_last stay stable while m_valid && !m_ready.
- Shift latch: on an input handshake with the frame-start flag set, use shift for this sample and hold it. The frame-start flag then clears; it sets again after a handshake with s_last=1. A mid-frame change on shift is ignored until the next frame.
- Arithmetic: the exact value is x*2^k, with x the signed s_data and k the latched shift.
- If the value fits M_WIDTH signed, output it exactly. Otherwise output MAX (0 followed by all ones) for x>0 and MIN (1 followed by all zeros) for x<0.
- x=0 never saturates for any k. If k >= M_WIDTH, any nonzero x saturates.
- Exact MIN (for example -2^(M_WIDTH-1)) is not saturation.
- Saturation is determined in stage 2, with a sat bit carried alongside the data.
- Counter: increments on an output handshake (m_valid && m_ready) whose sample has sat=1. It holds at all-ones and never wraps. sat_flag sets on the same event.
- clear: if clear and an increment occur in the same cycle, clear wins (sat_count=0, sat_flag=0). clear does not affect the datapath.
- Reset mid-operation: in-flight samples are discarded, m_valid=0 on the cycle after reset, and the next accepted sample is treated as a frame start.

Test Plan:
- Defaults, shift=0, s_data=0xFFFF, then 0x7FFF -> m_data=0xFFFFFFFF, then 0x00007FFF, each 2 cycles after accept; sat_count=0.
- shift=17, s_data=0x4000 -> m_data=0x7FFFFFFF, sat_count=1, sat_flag=1. Then s_data=0xC000 -> m_data=0x80000000 (exact MIN), count stays 1.
- shift=16, s_data=0x8000 -> 0x80000000, no sat. Next frame shift=17, s_data=0x8000 -> 0x80000000 with sat_count incremented. shift=31, s_data=0x0000 -> 0x00000000, no sat.
- Frame latch: a 4-sample frame (s_last on the 4th) with shift changed 0->4 after sample 1 -> all 4 outputs use shift 0. The next frame uses 4, and m_last is asserted only on the 4th output.
- Backpressure: m_ready=0, offer 4 back-to-back samples -> 2 accepted, s_ready=0 thereafter, m_data stable. Release m_ready -> all 4 delivered in order, no drops or duplicates.
- Counter edges: force sat_count to all-ones via a long saturating run -> it holds. clear asserted in the same cycle as a saturated output transfer -> sat_count=0, sat_flag=0. Reset while v1=v2=1 -> m_valid=0 next cycle, and the next sample reloads shift.
